// File: rtl/imem_fetch_port_if.sv
// Fetch/load bundle between the fetch stage and the instruction memory.
// The master drives requests and loads; the slave returns responses.
interface imem_fetch_port_if #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic                  ReqValid;
  logic                  ReqReady;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic                  RspValid;
  logic                  RspReady;
  logic [DATA_WIDTH-1:0] RspData;
  logic [1:0]            RspFault;
  logic                  LoadWe;
  logic                  LoadPtrClr;
  logic [DATA_WIDTH-1:0] LoadData;
  logic [AW-1:0]         LoadPtr;

  modport master (
    output ReqValid, ReqAddr, RspReady,
    output LoadWe, LoadPtrClr, LoadData,
    input  ReqReady, RspValid, RspData,
    input  RspFault, LoadPtr
  );

  modport slave (
    input  ReqValid, ReqAddr, RspReady,
    input  LoadWe, LoadPtrClr, LoadData,
    output ReqReady, RspValid, RspData,
    output RspFault, LoadPtr
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Instruction memory: registered valid/ready fetch plus sequential loader.
// Define IMEM_FAULT_EN to enable alignment and range fault reporting.
module imem_fetch_port #(
  parameter int                   DEPTH      = 256,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic               CLK,
  input logic               Reset,
  imem_fetch_port_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [AW-1:0]         idx;
  logic [AW-1:0]         wr_idx;
  logic [1:0]            fault;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  accept;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_fault;
  logic [AW-1:0]         ptr;

  assign offset = bus.ReqAddr - BASE_ADDR;
  assign idx    = offset[AW+1:2];

  wire unused_off = ^{offset[1:0],
                      offset[ADDR_WIDTH-1:AW+2]};

`ifdef IMEM_FAULT_EN
  logic mis;
  logic oor;

  assign mis = |bus.ReqAddr[1:0];
  assign oor = (bus.ReqAddr < BASE_ADDR)
            || (|offset[ADDR_WIDTH-1:AW+2]);

  always_comb begin
    fault = 2'b00;
    unique case (1'b1)
      mis:         fault = 2'b01;
      !mis && oor: fault = 2'b10;
      default:     fault = 2'b00;
    endcase
  end
`else
  assign fault = 2'b00;
`endif

  assign rd_data = (fault != 2'b00)
                 ? '0 : mem[idx];

  assign bus.ReqReady = !bus.LoadWe
                     && (!rsp_valid || bus.RspReady);
  assign accept = bus.ReqValid && bus.ReqReady;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 2'b00;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_data;
      rsp_fault <= fault;
    end else if (bus.RspReady) begin
      rsp_valid <= 1'b0;
    end
  end

  // A clear together with a write targets word 0 in the same cycle.
  assign wr_idx = bus.LoadPtrClr ? '0 : ptr;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ptr <= '0;
    end else if (bus.LoadWe) begin
      ptr <= wr_idx + 1'b1;
    end else if (bus.LoadPtrClr) begin
      ptr <= '0;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (bus.LoadWe) begin
      mem[wr_idx] <= bus.LoadData;
    end
  end

  assign bus.RspValid = rsp_valid;
  assign bus.RspData  = rsp_data;
  assign bus.RspFault = rsp_fault;
  assign bus.LoadPtr  = ptr;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed plan steps then random traffic
// checked against an array/arithmetic reference model.
module tb_imem_fetch_port;
  localparam int          DEPTH = 256;
  localparam int          DW    = 32;
  localparam int          AWID  = 64;
  localparam logic [63:0] BASE  = 64'h0;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  imem_fetch_port_if #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AWID)
  ) bus ();

  imem_fetch_port #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AWID), .BASE_ADDR(BASE)
  ) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );

  logic [31:0] mmem [DEPTH];
  logic        mvalid;
  logic [31:0] mdata;
  logic [1:0]  mfault;
  int          mptr;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model_fetch(
    logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
`ifdef IMEM_FAULT_EN
    if (a[1:0] != 2'b00) return {2'b01, 32'h0};
    if (a < BASE || (off >> 2) >= 64'(DEPTH))
      return {2'b10, 32'h0};
    return {2'b00, mmem[off >> 2]};
`else
    return {2'b00, mmem[(off >> 2) % 64'(DEPTH)]};
`endif
  endfunction

  task automatic model_reset();
    mvalid = 1'b0;
    mdata  = 32'h0;
    mfault = 2'b00;
    mptr   = 0;
  endtask

  // Inputs already applied; predicts and checks one clock edge.
  task automatic step(string tag);
    logic rdy;
    logic [33:0] r;
    int wi;
    #1;
    rdy = !bus.LoadWe && (!mvalid || bus.RspReady);
    chk({tag, ".ready"}, 64'(bus.ReqReady), 64'(rdy));
    if (bus.ReqValid && rdy) begin
      r = model_fetch(bus.ReqAddr);
      mfault = r[33:32];
      mdata  = r[31:0];
      mvalid = 1'b1;
    end else if (mvalid && bus.RspReady) begin
      mvalid = 1'b0;
    end
    if (bus.LoadWe) begin
      wi = bus.LoadPtrClr ? 0 : mptr;
      mmem[wi] = bus.LoadData;
      mptr = (wi + 1) % DEPTH;
    end else if (bus.LoadPtrClr) begin
      mptr = 0;
    end
    @(posedge CLK);
    #1;
    chk({tag, ".valid"}, 64'(bus.RspValid), 64'(mvalid));
    chk({tag, ".data"}, 64'(bus.RspData), 64'(mdata));
    chk({tag, ".fault"}, 64'(bus.RspFault), 64'(mfault));
    chk({tag, ".ptr"}, 64'(bus.LoadPtr), 64'(mptr));
  endtask

  task automatic idle();
    bus.ReqValid   = 1'b0;
    bus.ReqAddr    = '0;
    bus.RspReady   = 1'b1;
    bus.LoadWe     = 1'b0;
    bus.LoadPtrClr = 1'b0;
    bus.LoadData   = '0;
  endtask

  task automatic fetch(logic [63:0] a, logic rr, string tag);
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = a;
    bus.RspReady = rr;
    step(tag);
    bus.ReqValid = 1'b0;
  endtask

  task automatic load(logic [31:0] d, logic clr, string tag);
    bus.LoadWe     = 1'b1;
    bus.LoadPtrClr = clr;
    bus.LoadData   = d;
    step(tag);
    bus.LoadWe     = 1'b0;
    bus.LoadPtrClr = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst.valid", 64'(bus.RspValid), 64'(0));
    chk("rst.data", 64'(bus.RspData), 64'(0));
    chk("rst.fault", 64'(bus.RspFault), 64'(0));
    chk("rst.ptr", 64'(bus.LoadPtr), 64'(0));
    chk("rst.ready", 64'(bus.ReqReady), 64'(1));

    bus.LoadPtrClr = 1'b1;
    step("clr");
    bus.LoadPtrClr = 1'b0;
    load(32'hAA1F03F4, 1'b0, "ld0");
    load(32'hF8400289, 1'b0, "ld1");
    load(32'hF840828A, 1'b0, "ld2");
    chk("ld.ptr3", 64'(bus.LoadPtr), 64'(3));

    fetch(64'h0, 1'b1, "b2b0");
    chk("b2b0.word", 64'(bus.RspData), 64'hAA1F03F4);
    fetch(64'h4, 1'b1, "b2b1");
    chk("b2b1.word", 64'(bus.RspData), 64'hF8400289);
    fetch(64'h8, 1'b1, "b2b2");
    chk("b2b2.word", 64'(bus.RspData), 64'hF840828A);
    chk("b2b2.valid", 64'(bus.RspValid), 64'(1));
    step("drain");

    fetch(64'h4, 1'b0, "bp.acc");
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = 64'h8;
    bus.RspReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp.hold");
      chk("bp.ready", 64'(bus.ReqReady), 64'(0));
      chk("bp.word", 64'(bus.RspData), 64'hF8400289);
    end
    bus.ReqValid = 1'b0;
    bus.RspReady = 1'b1;
    step("bp.drain");
    chk("bp.valid0", 64'(bus.RspValid), 64'(0));

`ifdef IMEM_FAULT_EN
    fetch(64'h6, 1'b1, "f.mis");
    chk("f.mis.code", 64'(bus.RspFault), 64'(1));
    chk("f.mis.zero", 64'(bus.RspData), 64'(0));
    fetch(64'h400, 1'b1, "f.oor");
    chk("f.oor.code", 64'(bus.RspFault), 64'(2));
    chk("f.oor.zero", 64'(bus.RspData), 64'(0));
    fetch(64'h3FC, 1'b1, "f.top");
    chk("f.top.code", 64'(bus.RspFault), 64'(0));
`else
    fetch(64'h400, 1'b1, "alias");
    chk("alias.word", 64'(bus.RspData), 64'hAA1F03F4);
    chk("alias.code", 64'(bus.RspFault), 64'(0));
`endif
    step("drain2");

    bus.ReqValid = 1'b1;
    bus.ReqAddr  = 64'h0;
    load(32'h12345678, 1'b0, "prio");
    bus.ReqValid = 1'b0;
    chk("prio.noacc", 64'(bus.RspValid), 64'(0));

    bus.LoadPtrClr = 1'b1;
    step("wclr");
    bus.LoadPtrClr = 1'b0;
    for (int i = 0; i < 257; i++)
      load(32'hC0DE0000 + 32'(i), 1'b0, "wrap");
    chk("wrap.ptr", 64'(bus.LoadPtr), 64'(1));
    fetch(64'h0, 1'b1, "wrap.rd");
    chk("wrap.word", 64'(bus.RspData), 64'hC0DE0100);
    step("drain3");

    fetch(64'h0, 1'b0, "mid.acc");
    Reset = 1'b1;
    #1;
    chk("mid.valid", 64'(bus.RspValid), 64'(0));
    model_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    bus.RspReady = 1'b1;
    fetch(64'h0, 1'b1, "mid.rd");
    chk("mid.word", 64'(bus.RspData), 64'hC0DE0100);
    step("drain4");

    for (int i = 0; i < 2000; i++) begin
      bus.LoadWe     = ($urandom_range(0, 7) == 0);
      bus.LoadPtrClr = ($urandom_range(0, 15) == 0);
      bus.LoadData   = $urandom;
      bus.ReqValid   = ($urandom_range(0, 3) != 0);
      bus.RspReady   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1: bus.ReqAddr = 64'($urandom_range(0, 255)) * 4;
        2:    bus.ReqAddr = 64'($urandom_range(0, 1100));
        default: bus.ReqAddr = {$urandom, $urandom};
      endcase
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, synchronous instruction memory with a valid/ready fetch port, a one-cycle registered read and a sequential program-load port. It replaces the combinational hard-coded instruction table in the processor's fetch stage. The fetch stage or a testbench loader writes the program at run time. Misaligned and out-of-range fetches are reported instead of returning X.

## Interface
Parameters:
- DEPTH, 256: number of instruction words; power of two, minimum 4.
- DATA_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 64: byte-address width of ReqAddr.
- BASE_ADDR, 64'h0: byte address of word 0; must be 4-byte aligned.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  fetch request present.
- ReqReady  out  1  request accepted this cycle when ReqValid && ReqReady.
- ReqAddr  in  ADDR_WIDTH  byte address of the instruction.
- RspValid  out  1  response held in the output register.
- RspReady  in  1  consumer takes the response this cycle when RspValid && RspReady.
- RspData  out  DATA_WIDTH  instruction word.
- RspFault  out  2  00 ok, 01 misaligned, 10 out of range.
- LoadWe  in  1  write LoadData at the load pointer, then increment the pointer.
- LoadPtrClr  in  1  set the load pointer to 0.
- LoadData  in  DATA_WIDTH  word to write.
- LoadPtr  out  $clog2(DEPTH)  current load pointer.

## Operation
- Storage: DEPTH x DATA_WIDTH array.
  - Not cleared by Reset; contents survive Reset.
  - Never-written words read as X.
- Word index: (ReqAddr - BASE_ADDR) >> 2, taking the low $clog2(DEPTH) bits.
- Fetch:
  - ReqReady = !LoadWe && (!RspValid || RspReady).
  - On accept, the output register loads the indexed word and fault code, and RspValid goes to 1.
  - If RspValid && RspReady with no new accept, RspValid goes to 0.
  - While RspValid && !RspReady, RspData and RspFault hold stable.
- Fault checks apply when IMEM_FAULT_EN is defined:
  - ReqAddr[1:0] != 0 gives fault 01.
  - Otherwise, ReqAddr < BASE_ADDR, or (ReqAddr - BASE_ADDR) >> 2 >= DEPTH, gives fault 10.
  - Misaligned takes priority over out of range.
  - Any fault forces RspData to 0.
  - A faulting request still completes the handshake normally.
- Load:
  - LoadWe writes mem[LoadPtr] = LoadData and sets LoadPtr to LoadPtr + 1, wrapping from DEPTH-1 to 0.
  - When LoadPtrClr and LoadWe are both asserted, the write goes to index 0 and LoadPtr becomes 1.
  - When LoadPtrClr is asserted alone, LoadPtr becomes 0.
- Load has priority: LoadWe forces ReqReady to 0. A pending response is unaffected and can still be drained.
- Because of that priority, read-during-write to the same word is impossible.

## Timing
- Reset values: RspValid = 0, RspData = 0, RspFault = 00, LoadPtr = 0.
  - ReqReady = 1 while Reset is deasserted and LoadWe = 0.
- Reset asserted mid-transaction discards the pending response immediately (asynchronous). Memory contents are kept.
- Latency: accept at edge N gives RspValid = 1 with data from edge N.
- Throughput: one fetch per cycle when RspReady is held at 1.
- Back-to-back with RspReady = 1: accept and drain occur in the same cycle, and RspValid stays 1.
- A load written at edge N is visible to a fetch accepted at edge N+1 or later.
- ReqReady is combinational from RspValid, RspReady and LoadWe. There is no combinational path from ReqAddr to any output.

## Configuration
- IMEM_FAULT_EN defined:
  - Alignment and range checks are active as described in Operation.
- IMEM_FAULT_EN undefined:
  - No checks; RspFault is tied to 00.
  - ReqAddr[1:0] is ignored.
  - The index wraps modulo DEPTH (aliasing), including addresses below BASE_ADDR.
  - Area and timing drop accordingly.

## Test plan
- Reset -> RspValid = 0, RspData = 0, RspFault = 00, LoadPtr = 0, ReqReady = 1.
- Load, then fetch:
  - Stimulus: LoadPtrClr, then LoadWe with AA1F03F4, F8400289, F840828A; then fetch 0x0, 0x4, 0x8 back-to-back with RspReady = 1.
  - Response: LoadPtr = 3; RspData is AA1F03F4, F8400289, F840828A on consecutive cycles, one cycle after each accept.
- Backpressure:
  - Stimulus: fetch 0x4 with RspReady = 0 for 3 cycles.
  - Response: ReqReady = 0, and RspData = F8400289 holds stable. After RspReady = 1 for one cycle, RspValid = 0 with no new request.
- Faults (IMEM_FAULT_EN defined, DEPTH = 256):
  - Fetch 0x6 -> RspFault = 01, RspData = 0.
  - Fetch 0x400 -> RspFault = 10, RspData = 0.
  - Fetch 0x3FC -> RspFault = 00.
  - Without the macro, fetch 0x400 -> returns word 0 (AA1F03F4).
- Load priority and wrap:
  - LoadWe asserted while ReqValid = 1 -> ReqReady = 0, no accept.
  - 257 consecutive LoadWe writes -> LoadPtr = 1, word 0 holds the 257th value.
- Reset mid-transaction:
  - Stimulus: assert Reset while RspValid = 1.
  - Response: RspValid = 0 immediately; after release, a fetch of 0x0 returns the previously loaded word.
